// File: rtl/axi_rd_slave_q_if.sv
// axi_rd_slave_q_if: AXI3 read-address and read-data channel bundle
interface axi_rd_slave_q_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [3:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic [1:0]        ARLOCK;
  logic [3:0]        ARCACHE;
  logic [2:0]        ARPROT;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;
  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_rd_slave_q.sv
// axi_rd_slave_q: AXI3 read slave with in-order AR queue, FIXED/INCR/WRAP beat addressing and a synchronous device port
module axi_rd_slave_q #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int ID_W     = 4,
  parameter int AR_DEPTH = 4
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  axi_rd_slave_q_if.slave    ax,
  output logic [ADDR_W-1:0]  address_out,
  output logic               devread,
  input  logic [DATA_W-1:0]  data_in
);
  localparam int PW     = $clog2(AR_DEPTH);
  localparam int SZ_MAX = $clog2(DATA_W / 8);
  typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [8:0]        attr;
  } req_t;
  req_t              mem_q [AR_DEPTH];
  req_t              hd;
  logic [PW:0]       wp_q, wp_d, rp_q, rp_d;
  logic              up_q, full, empty, push, pop, hd_err, unused_attr;
  logic [ADDR_W-1:0] hd_b, b, t, inc, base, nxt;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        len_q, len_d, cnt_q, cnt_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [8:0]        attr_q, attr_d;
  assign full  = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
  assign empty = wp_q == rp_q;
  assign ax.ARREADY = up_q && !full;
  assign push  = ax.ARVALID && ax.ARREADY;
  assign pop   = state_q == IDLE && !empty;
  assign wp_d  = push ? wp_q + (PW+1)'(1) : wp_q;
  assign rp_d  = pop ? rp_q + (PW+1)'(1) : rp_q;
  assign hd    = mem_q[rp_q[PW-1:0]];
  assign hd_b  = ADDR_W'(1) << hd.size;
  // WRAP needs len+1 to be a power of two (2..16) and a size-aligned start
  assign hd_err = hd.burst == 2'b11 || int'(hd.size) > SZ_MAX ||
                  (hd.burst == 2'b10 && (hd.len == 4'd0 || (hd.len & (hd.len + 4'd1)) != 4'd0 ||
                                         (hd.addr & (hd_b - ADDR_W'(1))) != '0));
  assign b    = ADDR_W'(1) << size_q;
  assign t    = b * ADDR_W'({1'b0, len_q} + 5'd1);
  assign inc  = addr_q + b;
  assign base = addr_q & ~(t - ADDR_W'(1));
  assign nxt  = burst_q == 2'b00 ? addr_q :
                burst_q == 2'b10 ? (inc == base + t ? base : inc) :
                (addr_q & ~(b - ADDR_W'(1))) + b;
  assign ax.RVALID  = state_q == RESP;
  assign ax.RLAST   = ax.RVALID && cnt_q == len_q;
  assign ax.RID     = rid_q;
  assign ax.RDATA   = rdata_q;
  assign ax.RRESP   = err_q ? 2'b10 : 2'b00;
  assign devread    = state_q == FETCH && !err_q;
  assign address_out = addr_q;
  assign unused_attr = ^attr_q;
  always_ff @(posedge ACLK)
    if (push) mem_q[wp_q[PW-1:0]] <= '{id: ax.ARID, addr: ax.ARADDR, len: ax.ARLEN, size: ax.ARSIZE,
                                       burst: ax.ARBURST, attr: {ax.ARLOCK, ax.ARCACHE, ax.ARPROT}};
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    burst_d = burst_q;
    rid_d   = rid_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    attr_d  = attr_q;
    case (state_q)
      IDLE: if (pop) begin
        state_d = FETCH;
        addr_d  = hd.addr;
        len_d   = hd.len;
        cnt_d   = 4'd0;
        size_d  = hd.size;
        burst_d = hd.burst;
        rid_d   = hd.id;
        err_d   = hd_err;
        attr_d  = hd.attr;
      end
      FETCH: state_d = DATA;
      DATA: begin
        rdata_d = err_q ? '0 : data_in;
        state_d = RESP;
      end
      default: if (ax.RREADY) begin
        state_d = cnt_q == len_q ? IDLE : FETCH;
        cnt_d   = cnt_q == len_q ? cnt_q : cnt_q + 4'd1;
        addr_d  = cnt_q == len_q ? addr_q : nxt;
      end
    endcase
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      up_q    <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      rid_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      attr_q  <= '0;
    end else begin
      up_q    <= 1'b1;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      rid_q   <= rid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      attr_q  <= attr_d;
    end
  end
endmodule

// File: tb/tb_axi_rd_slave_q.sv
// tb_axi_rd_slave_q: directed checks of reset, burst addressing, error bursts, queue depth and backpressure
module tb_axi_rd_slave_q;
  localparam logic [31:0] K = 32'h5A5A0000;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [31:0] address_out;
  logic [31:0] data_in = '0;
  logic devread;
  int checks = 0;
  int fails = 0;
  int dr_cnt = 0;
  logic [31:0] addrs [$];
  always #5 clk = ~clk;
  axi_rd_slave_q_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) ax ();
  axi_rd_slave_q #(.DATA_W(32), .ADDR_W(32), .ID_W(4), .AR_DEPTH(4)) dut (
    .ACLK(clk), .ARESETn(rstn), .ax(ax.slave),
    .address_out(address_out), .devread(devread), .data_in(data_in)
  );
  // device model: data is the read address xor a tag, returned one cycle after the strobe
  always @(posedge clk)
    if (devread) begin
      addrs.push_back(address_out);
      dr_cnt++;
      data_in <= address_out ^ K;
    end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                    input logic [2:0] size, input logic [1:0] bt);
    int n = 0;
    @(negedge clk);
    ax.ARID = id; ax.ARADDR = addr; ax.ARLEN = len; ax.ARSIZE = size; ax.ARBURST = bt;
    ax.ARLOCK = 2'b01; ax.ARCACHE = 4'b0011; ax.ARPROT = 3'b010; ax.ARVALID = 1'b1;
    while (!ax.ARREADY && n < 50) begin @(negedge clk); n++; end
    check("ar_accept", ax.ARREADY, 1);
    @(posedge clk);
    #1 ax.ARVALID = 1'b0;
  endtask
  task automatic beat(input string tag, input logic [3:0] id, input logic [31:0] data,
                      input logic [1:0] resp, input logic last, input int stall);
    int n = 0;
    logic [37:0] snap;
    while (!ax.RVALID && n < 100) begin @(negedge clk); n++; end
    check({tag, "_rvalid"}, ax.RVALID, 1);
    check({tag, "_rid"}, ax.RID, id);
    check({tag, "_rdata"}, ax.RDATA, data);
    check({tag, "_rresp"}, ax.RRESP, resp);
    check({tag, "_rlast"}, ax.RLAST, last);
    snap = {ax.RVALID, ax.RLAST, ax.RID, ax.RDATA};
    repeat (stall) begin
      @(negedge clk);
      check({tag, "_hold"}, {ax.RVALID, ax.RLAST, ax.RID, ax.RDATA}, snap);
    end
    @(negedge clk);
    ax.RREADY = 1'b1;
    @(posedge clk);
    #1 ax.RREADY = 1'b0;
  endtask
  task automatic burst(input string tag, input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] bt, input logic err,
                       input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] a3);
    logic [31:0] ea [4];
    int d0;
    ea[0] = a0; ea[1] = a1; ea[2] = a2; ea[3] = a3;
    addrs.delete();
    d0 = dr_cnt;
    ar(id, addr, len, size, bt);
    for (int i = 0; i <= int'(len); i++)
      beat(tag, id, err ? 32'h0 : ea[i] ^ K, err ? 2'b10 : 2'b00, i == int'(len), 0);
    check({tag, "_devreads"}, dr_cnt - d0, err ? 0 : int'(len) + 1);
    for (int i = 0; i < addrs.size() && i <= int'(len); i++)
      check({tag, "_addr"}, addrs[i], ea[i]);
  endtask
  initial begin
    int acc;
    int d0;
    ax.ARID = 4'h9; ax.ARADDR = 32'h1234; ax.ARLEN = 4'd0; ax.ARSIZE = 3'd2; ax.ARBURST = 2'b01;
    ax.ARLOCK = '0; ax.ARCACHE = '0; ax.ARPROT = '0; ax.ARVALID = 1'b1; ax.RREADY = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_arready", ax.ARREADY, 0);
    check("rst_rvalid", ax.RVALID, 0);
    check("rst_rlast", ax.RLAST, 0);
    check("rst_devread", devread, 0);
    check("rst_outs", {ax.RDATA, ax.RID, ax.RRESP, address_out}, 0);
    rstn = 1'b1;
    ax.ARVALID = 1'b0;
    @(negedge clk);
    check("post_rst_arready", ax.ARREADY, 1);
    repeat (5) @(negedge clk);
    check("rst_no_push_rvalid", ax.RVALID, 0);
    check("rst_no_push_devread", dr_cnt, 0);
    burst("incr", 4'd5, 32'h102, 4'd3, 3'd2, 2'b01, 1'b0, 32'h102, 32'h104, 32'h108, 32'h10C);
    burst("wrap", 4'd2, 32'h38, 4'd3, 3'd2, 2'b10, 1'b0, 32'h38, 32'h3C, 32'h30, 32'h34);
    burst("fixed", 4'd3, 32'h40, 4'd2, 3'd2, 2'b00, 1'b0, 32'h40, 32'h40, 32'h40, 32'h0);
    burst("bad_burst", 4'd6, 32'h20, 4'd1, 3'd2, 2'b11, 1'b1, 0, 0, 0, 0);
    burst("bad_wraplen", 4'd7, 32'h10, 4'd2, 3'd2, 2'b10, 1'b1, 0, 0, 0, 0);
    burst("bad_size", 4'd1, 32'h0, 4'd0, 3'd3, 2'b01, 1'b1, 0, 0, 0, 0);
    burst("bad_wrapalign", 4'd4, 32'h22, 4'd1, 3'd2, 2'b10, 1'b1, 0, 0, 0, 0);
    acc = 0;
    addrs.delete();
    @(negedge clk);
    ax.ARLEN = 4'd0; ax.ARSIZE = 3'd2; ax.ARBURST = 2'b01; ax.ARVALID = 1'b1;
    repeat (10) begin
      ax.ARID = 4'(8 + acc);
      ax.ARADDR = 32'h200 + 32'(16 * acc);
      if (ax.ARREADY) acc++;
      @(negedge clk);
    end
    check("queue_accepted", acc, 5);
    check("queue_full_arready", ax.ARREADY, 0);
    ax.ARVALID = 1'b0;
    for (int i = 0; i < 5; i++)
      beat("queue_drain", 4'(8 + i), (32'h200 + 32'(16 * i)) ^ K, 2'b00, 1'b1, int'($urandom_range(0, 3)));
    check("queue_devreads", addrs.size(), 5);
    burst("incr_again", 4'd11, 32'h500, 4'd1, 3'd1, 2'b01, 1'b0, 32'h500, 32'h502, 0, 0);
    ar(4'd1, 32'h300, 4'd7, 3'd2, 2'b01);
    acc = 0;
    while (!ax.RVALID && acc < 100) begin @(negedge clk); acc++; end
    check("mid_rvalid", ax.RVALID, 1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_rvalid", ax.RVALID, 0);
    check("mid_rst_arready", ax.ARREADY, 0);
    rstn = 1'b1;
    d0 = dr_cnt;
    repeat (10) @(negedge clk);
    check("mid_rst_no_beats", ax.RVALID, 0);
    check("mid_rst_no_reads", dr_cnt - d0, 0);
    check("mid_rst_arready_back", ax.ARREADY, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
